// File: rtl/uart_pkg.sv
// Shared types and helpers for the streaming UART transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      EVEN = 2'd1,
      ODD  = 2'd2
   } parity_e;

   typedef struct packed {
      logic [1:0]  cnt;
      logic [31:0] dat;
   } tx_word_t;

   localparam int WORD_W = $bits(tx_word_t);

   // XOR of the low nbits of a character, inverted for odd parity.
   function automatic logic char_parity(input logic [7:0] ch, input int nbits, input logic odd);
      logic acc;
      acc = odd;
      for (int i = 0; i < 8; i++) begin
         if (i < nbits) acc = acc ^ ch[i];
         else           acc = acc;
      end
      return acc;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO; full/empty are derived only from the registered occupancy,
// so a same-cycle pop never frees room for a write into a full FIFO.
module sync_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      level_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign full      = (level_r == (AW+1)'(DEPTH));
   assign empty     = (level_r == '0);
   assign do_push_s = push & ~full;
   assign do_pop_s  = pop & ~empty;
   assign dout      = mem_r[rd_ptr_r];
   assign level     = level_r;

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         level_r  <= '0;
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
         case ({do_push_s, do_pop_s})
            2'b10:   level_r <= level_r + 1'b1;
            2'b01:   level_r <= level_r - 1'b1;
            default: level_r <= level_r;
         endcase
      end
   end

   // Storage array (data contents need no reset).
   always_ff @(posedge clk) begin
      if (do_push_s) mem_r[wr_ptr_r] <= din;
   end

endmodule

// File: rtl/uart_tx_stream.sv
// Streaming UART transmitter: 32-bit words carrying 1..4 characters are buffered
// in a FIFO and serialized LSB-first with optional parity and one or two stop bits.
module uart_tx_stream
   import uart_pkg::*;
#(
   parameter int BAUD_DIV   = 54,
   parameter int FIFO_DEPTH = 8,
   parameter int DATA_BITS  = 8
) (
   input  logic                          clk,
   input  logic                          Rst,
   input  logic                          wr_en,
   input  logic [31:0]                   wr_dat,
   input  logic [1:0]                    wr_bytes,
   input  logic [1:0]                    parity_mode,
   input  logic                          stop2,
   output logic                          wr_rdy,
   output logic                          wr_ack,
   output logic                          ovf,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   level
);
   localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
   localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

   tx_state_e   state_r;
   logic [15:0] baud_cnt_r;
   logic [2:0]  bit_idx_r;
   logic [1:0]  char_idx_r;
   logic [1:0]  last_char_r;
   logic [31:0] word_r;
   logic        par_en_r, par_odd_r, stop2_r, stop_cnt_r;
   logic        tx_r, wr_ack_r, ovf_r;

   tx_word_t    fifo_din_s, fifo_dout_s;
   logic        fifo_full_s, fifo_empty_s, push_s, pop_s;
   logic        bit_end_s, last_stop_s, parity_bit_s;
   logic [2:0]  next_bit_s;
   logic [7:0]  cur_char_s;

   assign fifo_din_s.cnt = wr_bytes;
   assign fifo_din_s.dat = wr_dat;
   assign push_s         = wr_en & ~fifo_full_s & ~Rst;
   assign bit_end_s      = (baud_cnt_r == 16'd0);
   assign last_stop_s    = ~stop2_r | stop_cnt_r;
   assign next_bit_s     = bit_idx_r + 3'd1;
   assign cur_char_s     = word_r[{char_idx_r, 3'b000} +: 8];
   assign parity_bit_s   = char_parity(cur_char_s, DATA_BITS, par_odd_r);

   sync_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (Rst),
      .push  (push_s),
      .din   (fifo_din_s),
      .pop   (pop_s),
      .dout  (fifo_dout_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .level (level)
   );

   // Pop from idle, or straight from the final stop bit of the last character.
   always_comb begin
      pop_s = 1'b0;
      if (Rst)
         pop_s = 1'b0;
      else if (state_r == IDLE)
         pop_s = ~fifo_empty_s;
      else if (state_r == STOP && bit_end_s && last_stop_s && char_idx_r == last_char_r)
         pop_s = ~fifo_empty_s;
      else
         pop_s = 1'b0;
   end

   // Serializer FSM with baud down-counter; frame options latch at pop.
   always_ff @(posedge clk) begin
      if (Rst) begin
         state_r     <= IDLE;
         baud_cnt_r  <= BAUD_LAST;
         bit_idx_r   <= 3'd0;
         char_idx_r  <= 2'd0;
         last_char_r <= 2'd0;
         word_r      <= 32'd0;
         par_en_r    <= 1'b0;
         par_odd_r   <= 1'b0;
         stop2_r     <= 1'b0;
         stop_cnt_r  <= 1'b0;
         tx_r        <= 1'b1;
      end else if (pop_s) begin
         state_r     <= START;
         baud_cnt_r  <= BAUD_LAST;
         word_r      <= fifo_dout_s.dat;
         last_char_r <= fifo_dout_s.cnt - 2'd1;
         char_idx_r  <= 2'd0;
         stop_cnt_r  <= 1'b0;
         stop2_r     <= stop2;
         tx_r        <= 1'b0;
         case (parity_e'(parity_mode))
            EVEN:    begin par_en_r <= 1'b1; par_odd_r <= 1'b0; end
            ODD:     begin par_en_r <= 1'b1; par_odd_r <= 1'b1; end
            default: begin par_en_r <= 1'b0; par_odd_r <= 1'b0; end
         endcase
      end else if (state_r == IDLE) begin
         baud_cnt_r <= BAUD_LAST;
         tx_r       <= 1'b1;
      end else if (!bit_end_s) begin
         baud_cnt_r <= baud_cnt_r - 16'd1;
      end else begin
         baud_cnt_r <= BAUD_LAST;
         case (state_r)
            START: begin
               state_r   <= DATA;
               bit_idx_r <= 3'd0;
               tx_r      <= cur_char_s[0];
            end
            DATA: begin
               if (bit_idx_r == LAST_BIT) begin
                  if (par_en_r) begin
                     state_r <= PARITY;
                     tx_r    <= parity_bit_s;
                  end else begin
                     state_r    <= STOP;
                     stop_cnt_r <= 1'b0;
                     tx_r       <= 1'b1;
                  end
               end else begin
                  bit_idx_r <= next_bit_s;
                  tx_r      <= cur_char_s[next_bit_s];
               end
            end
            PARITY: begin
               state_r    <= STOP;
               stop_cnt_r <= 1'b0;
               tx_r       <= 1'b1;
            end
            STOP: begin
               if (!last_stop_s) begin
                  stop_cnt_r <= 1'b1;
                  tx_r       <= 1'b1;
               end else if (char_idx_r != last_char_r) begin
                  char_idx_r <= char_idx_r + 2'd1;
                  state_r    <= START;
                  tx_r       <= 1'b0;
               end else begin
                  state_r <= IDLE;
                  tx_r    <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               tx_r    <= 1'b1;
            end
         endcase
      end
   end

   // Write acknowledge / overflow strobes, one cycle after the attempt.
   always_ff @(posedge clk) begin
      if (Rst) begin
         wr_ack_r <= 1'b0;
         ovf_r    <= 1'b0;
      end else begin
         wr_ack_r <= push_s;
         ovf_r    <= wr_en & fifo_full_s;
      end
   end

   assign wr_rdy = ~fifo_full_s;
   assign wr_ack = wr_ack_r;
   assign ovf    = ovf_r;
   assign tx     = tx_r;
   assign busy   = (state_r != IDLE) | ~fifo_empty_s;

endmodule
